seq_match_ctrl: RTL

- Run controller for serial pattern detection: holds a programmable pattern/length/overlap configuration and arms or disarms a shift-register matcher on command.
- Counts matches, stops after a programmed target count, and reports status.
- Sits between the control/config side and the serial bit source; it generalises the fixed-pattern detector FSM into a configurable, countable, abortable run.

---
 rtl/seq_match_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_match_ctrl.sv
// Run controller for a configurable serial pattern matcher.
// Holds the pattern, length, overlap and target configuration. Arms a
// shift-register matcher on start and counts matches. The run ends when the
// target is reached, or on abort. The optional accepted-bit timeout is
// compiled in when SEQ_TIMEOUT_EN is defined.
module seq_match_ctrl #(
  parameter int          PW          = 8,
  parameter int          CW          = 8,
  parameter logic [PW-1:0] DEF_PATTERN = 8'b0000_1011,
  parameter int          DEF_LEN     = 4,
  parameter int          TMO_BITS    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pattern,
  input  logic [3:0]    cfg_len,
  input  logic          cfg_overlap,
  input  logic [CW-1:0] cfg_target,
  input  logic          start,
  input  logic          abort,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          det,
  output logic [CW-1:0] match_count,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  localparam int FW = $clog2(PW + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          det_q, det_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] history_q, history_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [PW-1:0] pattern_q, pattern_d;
  logic [3:0]    len_q, len_d;
  logic          overlap_q, overlap_d;
  logic [CW-1:0] target_q, target_d;
  logic          timeout_q, timeout_d;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_BITS + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_expire;
`endif

  // Combinational helpers for the matcher datapath.
  logic [PW-1:0] hist_new;
  logic [FW:0]   fill_inc;
  logic [FW-1:0] fill_sat;
  logic [PW-1:0] len_mask;
  logic          hit;
  logic [CW-1:0] count_inc;
  logic          target_hit;
  logic [3:0]    len_clamped;

  assign hist_new = {history_q[PW-2:0], bit_in};
  assign fill_inc = {1'b0, fill_q} + {{FW{1'b0}}, 1'b1};
  assign fill_sat = (32'(fill_inc) > PW) ? FW'(PW) : fill_inc[FW-1:0];

  // One mask bit per pattern position that lies inside the active length.
  for (genvar gi = 0; gi < PW; gi++) begin : g_mask
    assign len_mask[gi] = (32'(len_q) > gi);
  end

  // A match needs enough fresh bits and equality on the active window.
  assign hit = (32'(fill_inc) >= 32'(len_q)) &&
               (((hist_new ^ pattern_q) & len_mask) == '0);

  assign count_inc  = (count_q == {CW{1'b1}}) ? count_q : count_q + 1'b1;
  assign target_hit = (target_q != '0) && (count_inc == target_q);

  assign len_clamped = (cfg_len == 4'd0)     ? 4'd1 :
                       (32'(cfg_len) > PW)   ? 4'(PW) : cfg_len;

`ifdef SEQ_TIMEOUT_EN
  // The window expires on the edge that accepts the TMO_BITS-th bit.
  assign tmo_expire = (32'(tmo_cnt_q) + 1 >= TMO_BITS);
`endif

  // Next-state, configuration and matcher update logic.
  always_comb begin
    state_d   = state_q;
    det_d     = 1'b0;
    count_d   = count_q;
    history_d = history_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    timeout_d = timeout_q;
`ifdef SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    // Configuration may only change while no run is active.
    if (cfg_we && (state_q != SEARCH)) begin
      pattern_d = cfg_pattern;
      len_d     = len_clamped;
      overlap_d = cfg_overlap;
      target_d  = cfg_target;
    end

    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d   = SEARCH;
          history_d = '0;
          fill_d    = '0;
          count_d   = '0;
          timeout_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      SEARCH: begin
        if (abort) begin
          // Any match on this edge is dropped; the count is held.
          state_d = IDLE;
        end else if (bit_valid) begin
          history_d = hist_new;
          fill_d    = fill_sat;
`ifdef SEQ_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
          if (hit) begin
            det_d   = 1'b1;
            count_d = count_inc;
            if (!overlap_q) begin
              fill_d = '0;
            end
`ifdef SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            if (target_hit) begin
              state_d = DONE;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (tmo_expire) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      det_q     <= 1'b0;
      count_q   <= '0;
      history_q <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      len_q     <= 4'(DEF_LEN);
      overlap_q <= 1'b1;
      target_q  <= CW'(1);
      timeout_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      count_q   <= count_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      timeout_q <= timeout_d;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign det         = det_q;
  assign match_count = count_q;
  assign busy        = (state_q == SEARCH);
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q && (state_q == DONE);

endmodule
